// File: rtl/dct8_butterfly_in_if.sv
// Bus bundle for the DCT-8 input butterfly: serial sample input side and
// the registered even/odd butterfly outputs with row framing flags.
interface dct8_butterfly_in_if #(
    parameter int IN_WIDTH = 9,
    parameter int WIDTH    = 19
);
    logic                       in_valid;
    logic                       in_sync;
    logic signed [IN_WIDTH-1:0] in_data;
    logic signed [WIDTH-1:0]    a0, a1, a2, a3;
    logic signed [WIDTH-1:0]    b0, b1, b2, b3;
    logic                       out_valid;
    logic [2:0]                 out_row;
    logic                       out_last;
    logic                       row_err;

    // Sample source / consumer of the butterfly results.
    modport master (
        output in_valid, in_sync, in_data,
        input  a0, a1, a2, a3, b0, b1, b2, b3,
        input  out_valid, out_row, out_last, row_err
    );

    // The butterfly block itself.
    modport slave (
        input  in_valid, in_sync, in_data,
        output a0, a1, a2, a3, b0, b1, b2, b3,
        output out_valid, out_row, out_last, row_err
    );
endinterface

// File: rtl/dct8_butterfly_in.sv
// Input stage of the 8-point HEVC forward DCT: gathers one row of eight
// serial residuals and registers the first butterfly (even sums a0..a3,
// odd differences b0..b3), tracking the row index and broken framing.
module dct8_butterfly_in #(
    parameter int IN_WIDTH = 9,
    parameter int WIDTH    = 19
) (
    input  logic              clk,
    input  logic              rst,
    dct8_butterfly_in_if.slave bus
);

    // Sign-extend one residual to the butterfly width; WIDTH >= IN_WIDTH+1
    // guarantees the sum/difference of two extended samples cannot overflow.
    function automatic logic signed [WIDTH-1:0] sx(input logic signed [IN_WIDTH-1:0] v);
        return {{(WIDTH-IN_WIDTH){v[IN_WIDTH-1]}}, v};
    endfunction

    logic signed [IN_WIDTH-1:0] x_q [0:6];
    logic signed [IN_WIDTH-1:0] x_d [0:6];
    logic signed [IN_WIDTH-1:0] full_row [0:7];
    logic [2:0]                 cnt_q, cnt_d;
    logic [2:0]                 rcnt_q, rcnt_d;
    logic signed [WIDTH-1:0]    a_q [0:3];
    logic signed [WIDTH-1:0]    a_d [0:3];
    logic signed [WIDTH-1:0]    b_q [0:3];
    logic signed [WIDTH-1:0]    b_d [0:3];
    logic [2:0]                 row_q, row_d;
    logic                       last_q, last_d;
    logic                       vld_p1_q, vld_p1_d;
    logic                       err_q, err_d;

    // Assemble the complete row: x0..x6 from storage, x7 straight from the input.
    always_comb begin
        for (int i = 0; i < 7; i++) begin
            full_row[i] = x_q[i];
        end
        full_row[7] = bus.in_data;
    end

    // Sample capture, framing decisions and the butterfly for the 8th sample.
    always_comb begin
        x_d      = x_q;
        cnt_d    = cnt_q;
        rcnt_d   = rcnt_q;
        a_d      = a_q;
        b_d      = b_q;
        row_d    = row_q;
        last_d   = last_q;
        vld_p1_d = 1'b0;
        err_d    = 1'b0;
        if (bus.in_valid) begin
            if (bus.in_sync) begin
                // A sync always starts a new row; any partial row is dropped.
                x_d[0] = bus.in_data;
                cnt_d  = 3'd1;
                err_d  = (cnt_q != 3'd0);
            end else if (cnt_q != 3'd7) begin
                for (int i = 0; i < 7; i++) begin
                    if (cnt_q == 3'(i)) begin
                        x_d[i] = bus.in_data;
                    end
                end
                cnt_d = cnt_q + 3'd1;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    a_d[i] = sx(full_row[i]) + sx(full_row[7-i]);
                    b_d[i] = sx(full_row[i]) - sx(full_row[7-i]);
                end
                cnt_d    = 3'd0;
                row_d    = rcnt_q;
                last_d   = (rcnt_q == 3'd7);
                rcnt_d   = rcnt_q + 3'd1;
                vld_p1_d = 1'b1;
            end
        end
    end

    // ---- stage p1: registered butterfly results and framing state ----
    // State register; reset clears everything including stored samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 7; i++) begin
                x_q[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            cnt_q    <= 3'd0;
            rcnt_q   <= 3'd0;
            row_q    <= 3'd0;
            last_q   <= 1'b0;
            vld_p1_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            x_q      <= x_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            rcnt_q   <= rcnt_d;
            row_q    <= row_d;
            last_q   <= last_d;
            vld_p1_q <= vld_p1_d;
            err_q    <= err_d;
        end
    end

    assign bus.a0        = a_q[0];
    assign bus.a1        = a_q[1];
    assign bus.a2        = a_q[2];
    assign bus.a3        = a_q[3];
    assign bus.b0        = b_q[0];
    assign bus.b1        = b_q[1];
    assign bus.b2        = b_q[2];
    assign bus.b3        = b_q[3];
    assign bus.out_valid = vld_p1_q;
    assign bus.out_row   = row_q;
    assign bus.out_last  = last_q;
    assign bus.row_err   = err_q;

endmodule

// File: tb/tb_dct8_butterfly_in.sv
// Self-checking bench for dct8_butterfly_in: randomized rows against a
// queue-based row model, plus the directed framing and extreme-value cases.
module tb_dct8_butterfly_in;
    localparam int IN_WIDTH = 9;
    localparam int WIDTH    = 19;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dct8_butterfly_in_if #(.IN_WIDTH(IN_WIDTH), .WIDTH(WIDTH)) bus ();

    dct8_butterfly_in #(.IN_WIDTH(IN_WIDTH), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: the samples of the row in progress, rows completed,
    // and the output values expected after the current clock edge.
    int m_q[$];
    int m_rows;
    int e_a[4], e_b[4];
    int e_vld, e_err, e_row, e_last;
    int vld_count;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_rows = 0;
        for (int i = 0; i < 4; i++) begin
            e_a[i] = 0;
            e_b[i] = 0;
        end
        e_vld  = 0;
        e_err  = 0;
        e_row  = 0;
        e_last = 0;
    endfunction

    function automatic void model_step(input bit v, input bit s, input int d);
        e_vld = 0;
        e_err = 0;
        if (!v) return;
        if (s) begin
            if (m_q.size() != 0) e_err = 1;
            m_q.delete();
            m_q.push_back(d);
        end else begin
            m_q.push_back(d);
            if (m_q.size() == 8) begin
                for (int i = 0; i < 4; i++) begin
                    e_a[i] = m_q[i] + m_q[7-i];
                    e_b[i] = m_q[i] - m_q[7-i];
                end
                e_row  = m_rows % 8;
                e_last = (e_row == 7);
                e_vld  = 1;
                m_rows++;
                m_q.delete();
            end
        end
    endfunction

    task automatic check_outputs();
        chk("out_valid", int'(bus.out_valid), e_vld);
        chk("row_err", int'(bus.row_err), e_err);
        chk("out_row", int'(bus.out_row), e_row);
        chk("out_last", int'(bus.out_last), e_last);
        chk("a0", int'(bus.a0), e_a[0]);
        chk("a1", int'(bus.a1), e_a[1]);
        chk("a2", int'(bus.a2), e_a[2]);
        chk("a3", int'(bus.a3), e_a[3]);
        chk("b0", int'(bus.b0), e_b[0]);
        chk("b1", int'(bus.b1), e_b[1]);
        chk("b2", int'(bus.b2), e_b[2]);
        chk("b3", int'(bus.b3), e_b[3]);
        if (bus.out_valid) vld_count++;
    endtask

    // One clock: drive inputs, let the edge happen, compare #1 later.
    task automatic do_cycle(input bit v, input bit s, input int d);
        bus.in_valid = v;
        bus.in_sync  = s;
        bus.in_data  = IN_WIDTH'(d);
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else model_step(v, s, d);
        check_outputs();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            do_cycle(1'($urandom), 1'($urandom), $urandom_range(0, 511) - 256);
        end
        rst = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            do_cycle(1'b0, 1'($urandom), $urandom_range(0, 511) - 256);
        end
    endtask

    // Send eight samples, optionally sync on x0, with 0..maxgap idle cycles between.
    task automatic send_row(input int vals[8], input bit sync_first, input int maxgap);
        for (int i = 0; i < 8; i++) begin
            if (i != 0 && maxgap > 0) idle($urandom_range(0, maxgap));
            do_cycle(1'b1, (i == 0) ? sync_first : 1'b0, vals[i]);
        end
    endtask

    function automatic void rand_row(output int vals[8]);
        for (int i = 0; i < 8; i++) vals[i] = $urandom_range(0, 511) - 256;
    endfunction

    initial begin
        int row[8];
        int saved_a[4], saved_b[4];
        int cyc_since;

        bus.in_valid = 1'b0;
        bus.in_sync  = 1'b0;
        bus.in_data  = '0;
        model_reset();

        // Reset state: everything zero even with traffic presented.
        do_reset(4);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_a0", int'(bus.a0), 0);
        idle(2);

        // Ramp 1..8 with sync on x0.
        for (int i = 0; i < 8; i++) row[i] = i + 1;
        send_row(row, 1'b1, 0);
        chk("ramp_valid", int'(bus.out_valid), 1);
        chk("ramp_a0", int'(bus.a0), 9);
        chk("ramp_a3", int'(bus.a3), 9);
        chk("ramp_b0", int'(bus.b0), -7);
        chk("ramp_b1", int'(bus.b1), -5);
        chk("ramp_b2", int'(bus.b2), -3);
        chk("ramp_b3", int'(bus.b3), -1);
        chk("ramp_row", int'(bus.out_row), 0);
        chk("ramp_last", int'(bus.out_last), 0);
        idle(3);

        // Extremes: 255 x4 then -256 x4.
        for (int i = 0; i < 8; i++) row[i] = (i < 4) ? 255 : -256;
        send_row(row, 1'b0, 0);
        chk("ext_a0", int'(bus.a0), -1);
        chk("ext_a2", int'(bus.a2), -1);
        chk("ext_b0", int'(bus.b0), 511);
        chk("ext_b3", int'(bus.b3), 511);
        chk("ext_row", int'(bus.out_row), 1);
        idle(2);

        // Nine back-to-back random rows from a fresh reset.
        do_reset(2);
        vld_count = 0;
        for (int r = 0; r < 9; r++) begin
            rand_row(row);
            send_row(row, r[0], 0);
            chk("b2b_row", int'(bus.out_row), r % 8);
            chk("b2b_last", int'(bus.out_last), (r == 7) ? 1 : 0);
        end
        chk("b2b_count", vld_count, 9);

        // Same row gapless then with random gaps: identical results.
        rand_row(row);
        send_row(row, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            saved_a[i] = int'(i == 0 ? bus.a0 : i == 1 ? bus.a1 : i == 2 ? bus.a2 : bus.a3);
            saved_b[i] = int'(i == 0 ? bus.b0 : i == 1 ? bus.b1 : i == 2 ? bus.b2 : bus.b3);
        end
        idle(4);
        vld_count = 0;
        send_row(row, 1'b1, 5);
        chk("gap_valid", int'(bus.out_valid), 1);
        chk("gap_a0", int'(bus.a0), saved_a[0]);
        chk("gap_a3", int'(bus.a3), saved_a[3]);
        chk("gap_b1", int'(bus.b1), saved_b[1]);
        chk("gap_b2", int'(bus.b2), saved_b[2]);
        idle(6);
        chk("gap_once", vld_count, 1);

        // Broken framing: 3 samples, sync with 10, 7 more samples.
        do_reset(1);
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, $urandom_range(0, 511) - 256);
        do_cycle(1'b1, 1'b1, 10);
        chk("sync_err", int'(bus.row_err), 1);
        rand_row(row);
        cyc_since = 0;
        for (int i = 1; i < 8; i++) do_cycle(1'b1, 1'b0, row[i]);
        chk("sync_valid", int'(bus.out_valid), 1);
        chk("sync_a0", int'(bus.a0), 10 + row[7]);
        chk("sync_b0", int'(bus.b0), 10 - row[7]);
        chk("sync_row", int'(bus.out_row), 0);
        rand_row(row);
        send_row(row, 1'b0, 0);
        chk("sync_row_next", int'(bus.out_row), 1);

        // Sync arriving when seven samples are held is also an error.
        for (int i = 0; i < 7; i++) do_cycle(1'b1, 1'b0, i);
        do_cycle(1'b1, 1'b1, 3);
        chk("sync7_err", int'(bus.row_err), 1);
        chk("sync7_valid", int'(bus.out_valid), 0);
        rand_row(row);
        for (int i = 1; i < 8; i++) do_cycle(1'b1, 1'b0, row[i]);
        chk("sync7_a3", int'(bus.a3), row[3] + row[4]);

        // Reset in the middle of a row, then a row without sync.
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, $urandom_range(0, 511) - 256);
        do_reset(3);
        chk("mid_rst_err", int'(bus.row_err), 0);
        rand_row(row);
        send_row(row, 1'b0, 2);
        chk("mid_rst_row", int'(bus.out_row), 0);
        chk("mid_rst_b3", int'(bus.b3), row[3] - row[4]);
        chk("mid_rst_err2", int'(bus.row_err), 0);

        // Mixed random traffic with occasional syncs.
        for (int i = 0; i < 600; i++) begin
            do_cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                     $urandom_range(0, 511) - 256);
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "time limit");
    end
endmodule

// File: doc/dct8_butterfly_in.md
# dct8_butterfly_in

Input stage of the 8-point HEVC forward DCT. It collects one row of eight residual samples, arriving serially one per valid cycle, and computes the first butterfly: even sums a0..a3 and odd differences b0..b3. The b outputs feed the odd-part shift-add stage (coefficients 89/75/50/18) directly. The a outputs feed the even-part stage. It also tracks the row index within the 8x8 block and flags rows whose framing was broken.

## Interface
- IN_WIDTH, 9, signed width of one input residual sample.
- WIDTH, 19, signed width of a0..a3 and b0..b3; must be >= IN_WIDTH+1.
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data carries a sample this cycle.
- in_sync  in  1  qualified by in_valid: this sample is x0 of a new row.
- in_data  in  IN_WIDTH  signed sample.
- a0..a3  out  WIDTH each  signed x_i + x_(7-i), registered.
- b0..b3  out  WIDTH each  signed x_i - x_(7-i), registered.
- out_valid  out  1  one-cycle pulse: a/b hold a new row.
- out_row  out  3  row index (0..7) of the row presented with out_valid.
- out_last  out  1  high with out_valid when out_row == 7.
- row_err  out  1  one-cycle pulse: a partial row was discarded.

## Operation
- Sample counter cnt (3 bits) gives the position of the next accepted sample. Row counter rcnt (3 bits) gives the index of the next row to complete.
- Sample storage: registers x0..x6. x7 is never stored; it is used directly from in_data.
- in_valid=0: no state changes. Gaps of any length are allowed between samples.
- in_valid=1, in_sync=0, cnt<7: store in_data into x[cnt], then cnt <= cnt+1.
- in_valid=1, in_sync=0, cnt==7: compute and register the butterfly.
  - a_i = sx(x_i) + sx(x_(7-i)), for i = 0..3, with x7 = in_data.
  - b_i = sx(x_i) - sx(x_(7-i)), for i = 0..3.
  - sx() sign-extends IN_WIDTH to WIDTH before the add or subtract. No overflow is possible.
  - Then cnt <= 0, out_row <= rcnt, rcnt <= rcnt+1 (wraps 7->0).
- in_valid=1, in_sync=1: store the sample as x0 and set cnt <= 1.
  - If cnt != 0 at that cycle, pulse row_err on the next cycle and drop the partial row. No output and no rcnt change for it.
  - in_sync when cnt==7 is also an error: the sample is taken as x0 of the new row and the old row is not completed.
- in_sync without in_valid is ignored.
- A row whose first sample arrives with in_sync=0 and cnt==0 is accepted as a normal row. Sync is optional for realignment only.
- a/b, out_row and out_last hold their values until the next completed row. out_valid and row_err are pulses.

## Timing
- Latency: a/b, out_row and out_last update, and out_valid is high, on the cycle after the 8th sample is accepted (one register stage).
- Maximum throughput: one row every 8 cycles with no idle cycles.
- A new row's samples may be accepted while the previous row's outputs are displayed. Back-to-back rows give an out_valid every 8th cycle.
- No backpressure. The downstream stages are free-running registers and always accept.
- Reset (rst=1 at a clock edge):
  - cnt, rcnt, x0..x6, a0..a3, b0..b3, out_row = 0.
  - out_valid, out_last, row_err = 0.
  - Samples presented during reset are dropped.
- Reset mid-row: the partial row is discarded silently. row_err does not pulse for it.
- row_err and out_valid never assert in the same cycle: an erroring sync sample cannot also be an 8th sample.

## Test plan
- Row x = 1,2,...,8, contiguous, first sample with in_sync -> one cycle later out_valid=1, a0..a3 = 9,9,9,9, b0..b3 = -7,-5,-3,-1, out_row=0, out_last=0.
- Extremes, IN_WIDTH=9: x0..x3 = 255 and x4..x7 = -256 -> a_i = -1 and b_i = 511 for all i, with correct sign extension to WIDTH.
- Eight back-to-back rows of random samples -> out_valid every 8 cycles, out_row steps 0..7, out_last only on row 7. A ninth row gives out_row=0. All a/b values match the reference model.
- Random in_valid gaps of 0..5 cycles inside one row -> identical a/b to the gapless case. out_valid occurs exactly once, one cycle after the 8th valid sample.
- 3 samples, then in_sync with value 10, then 7 more samples -> row_err pulse one cycle after the sync. The output row uses x0=10. rcnt advances by 1, not 2.
- rst asserted after 5 samples of a row, then a full row -> all outputs 0 during reset and no row_err. The following row produces out_row=0 with correct values.
